// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Single-owner arbiter for the shared system bus. Collects one request per bus
// master, grants the bus to exactly one master at a time under round-robin
// priority, and supervises the granted transfer with a watchdog counter that
// flags a slave that never returns its function-complete strobe.
//
// Parameters
//   MASTERS          number of requesting masters (>= 2)
//   WATCHDOG_CYCLES  granted cycles allowed without fc_bus before watchdog
//                    asserts (>= 1)
//
// Ports
//   clk        in   1        system clock, single domain
//   rst        in   1        synchronous active-high reset
//   bus_req    in   MASTERS  per-master request, bit i belongs to master i
//   bus_grant  out  MASTERS  registered one-hot grant, or all zero
//   fc_bus     in   1        function-complete strobe from the addressed slave
//   watchdog   out  1        registered timeout level to the granted master
//   bus_busy   out  1        registered, high while any grant is held
//
// Build option
//   BUS_ARBITER_WATCHDOG_EN  when defined, the watchdog counter, the fc_seen
//                            flag and the watchdog output are built. When
//                            undefined, watchdog is tied to 0 and fc_bus is
//                            not used; arbitration is unchanged.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MASTERS         = 2,
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MASTERS-1:0] bus_req,
    output logic [MASTERS-1:0] bus_grant,
    input  logic               fc_bus,
    output logic               watchdog,
    output logic               bus_busy
);

    localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;

    logic               winnerFound;
    logic [PW-1:0]      winnerIdx;
    logic               ownerReq;
    int                 searchIdx;

    // The owner keeps the bus exactly as long as its own request stays high;
    // requests from other masters never shorten a transfer.
    assign ownerReq = bus_req[owner_q];

    // Round-robin search: start at the priority pointer and walk upward,
    // wrapping past the last master, taking the first live request found.
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = '0;
        searchIdx   = 0;
        for (int i = 0; i < MASTERS; i++) begin
            searchIdx = int'(ptr_q) + i;
            if (searchIdx >= MASTERS) begin
                searchIdx = searchIdx - MASTERS;
            end
            if (!winnerFound && bus_req[searchIdx[PW-1:0]]) begin
                winnerFound = 1'b1;
                winnerIdx   = searchIdx[PW-1:0];
            end
        end
    end

    // State and arbitration registers. Reset drops any grant at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic. Leaving ACTIVE always passes through IDLE, which
    // forces one all-zero grant cycle between owners on the tri-state bus.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (winnerFound) state_d = ACTIVE;
            ACTIVE:  if (!ownerReq)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and pointer logic. The pointer only moves on release, so the
    // master after the last owner gets first look at the next arbitration.
    always_comb begin
        grant_d = grant_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (winnerFound) begin
                    grant_d[winnerIdx] = 1'b1;
                    busy_d             = 1'b1;
                    owner_d            = winnerIdx;
                end
            end
            ACTIVE: begin
                if (!ownerReq) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (owner_q == PW'(MASTERS - 1)) ? '0 : owner_q + PW'(1);
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus_grant = grant_q;
    assign bus_busy  = busy_q;

`ifdef BUS_ARBITER_WATCHDOG_EN
    logic [CW-1:0] count_q, count_d;
    logic          fcSeen_q, fcSeen_d;
    logic          wd_q, wd_d;

    // Watchdog registers; reset clears them without producing a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            fcSeen_q <= 1'b0;
            wd_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            fcSeen_q <= fcSeen_d;
            wd_q     <= wd_d;
        end
    end

    // The counter saturates rather than wrapping, so once watchdog is raised
    // it stays raised until the owner releases. An fc_bus arriving on the
    // cycle that would take the count to the limit blocks the increment, so
    // the slave's completion always beats the timeout.
    always_comb begin
        count_d  = count_q;
        fcSeen_d = fcSeen_q;
        wd_d     = wd_q;
        unique case (state_q)
            IDLE: begin
                wd_d = 1'b0;
                if (winnerFound) begin
                    count_d  = '0;
                    fcSeen_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (!ownerReq) begin
                    wd_d = 1'b0;
                end else if (fc_bus) begin
                    fcSeen_d = 1'b1;
                end else if (!fcSeen_q && (count_q != CW'(WATCHDOG_CYCLES))) begin
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WATCHDOG_CYCLES - 1)) begin
                        wd_d = 1'b1;
                    end
                end
            end
            default: wd_d = 1'b0;
        endcase
    end

    assign watchdog = wd_q;
`else
    // Without supervision a silent slave simply holds the bus until its owner
    // gives up; the completion strobe has no consumer.
    logic unusedFcBus;
    assign unusedFcBus = fc_bus;
    assign watchdog    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter with MASTERS=2, WATCHDOG_CYCLES=8. Each
// stimulus step drives the inputs for one cycle and queues the outputs the
// arbiter must show after the following clock edge. A separate monitor pops
// those expectations on the falling edge of the matching cycle and compares.
// Watchdog expectations follow BUS_ARBITER_WATCHDOG_EN so the same bench
// covers both builds.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

`ifdef BUS_ARBITER_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    typedef struct {
        int         target;
        int         tag;
        logic [1:0] grant;
        logic       busy;
        logic       wd;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] bus_req;
    logic [1:0] bus_grant;
    logic       fc_bus;
    logic       watchdog;
    logic       bus_busy;

    exp_t       expQ[$];
    int         cycleCount = 0;
    int         stepNo     = 0;
    int         checks     = 0;
    int         errors     = 0;

    bus_arbiter #(
        .MASTERS        (2),
        .WATCHDOG_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_req  (bus_req),
        .bus_grant(bus_grant),
        .fc_bus   (fc_bus),
        .watchdog (watchdog),
        .bus_busy (bus_busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Drive one cycle of inputs and queue the outputs expected after the
    // next rising edge.
    task automatic applyStimulus(input logic [1:0] req, input logic fc, input logic r,
                                 input logic [1:0] eg, input logic eb, input logic ew);
        exp_t e;
        @(posedge clk);
        #1;
        bus_req = req;
        fc_bus  = fc;
        rst     = r;
        stepNo++;
        e.target = cycleCount + 1;
        e.tag    = stepNo;
        e.grant  = eg;
        e.busy   = eb;
        e.wd     = ew;
        expQ.push_back(e);
    endtask

    // Compare one queued expectation against the live outputs.
    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus_grant !== e.grant) begin
            errors++;
            $display("[TB] FAIL step%0d grant: got %b expected %b", e.tag, bus_grant, e.grant);
        end
        checks++;
        if (bus_busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL step%0d busy: got %b expected %b", e.tag, bus_busy, e.busy);
        end
        checks++;
        if (watchdog !== e.wd) begin
            errors++;
            $display("[TB] FAIL step%0d watchdog: got %b expected %b", e.tag, watchdog, e.wd);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].target <= cycleCount) begin
            exp_t e;
            e = expQ.pop_front();
            if (e.target != cycleCount) begin
                checks++;
                errors++;
                $display("[TB] FAIL step%0d stale: got cycle %0d expected cycle %0d",
                         e.tag, cycleCount, e.target);
            end else begin
                checkOutput(e);
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "[TB] time limit expired");
    end

    initial begin
        logic [1:0] og;
        logic [1:0] dropReq;
        rst     = 1'b1;
        bus_req = 2'b00;
        fc_bus  = 1'b0;

        // Reset state
        applyStimulus(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);

        // Single grant with completion, then release; fc in IDLE is ignored
        $display("[TB] scenario 1: single transfer");
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Round-robin alternation with one idle cycle between owners
        $display("[TB] scenario 2: round robin");
        applyStimulus(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        for (int rep = 0; rep < 4; rep++) begin
            og      = (rep % 2 == 0) ? 2'b01 : 2'b10;
            dropReq = (rep % 2 == 0) ? 2'b10 : 2'b01;
            applyStimulus(2'b11,   1'b0, 1'b0, og,    1'b1, 1'b0);
            applyStimulus(2'b11,   1'b0, 1'b0, og,    1'b1, 1'b0);
            applyStimulus(2'b11,   1'b0, 1'b0, og,    1'b1, 1'b0);
            applyStimulus(dropReq, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Watchdog timeout: silent slave, owner gives up after the flag
        $display("[TB] scenario 3: watchdog timeout");
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        end
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b01, 1'b1, WD);
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b01, 1'b1, WD);
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Completion on the same cycle the count would hit the limit
        $display("[TB] scenario 4: fc beats watchdog");
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        end
        applyStimulus(2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Reset during an active grant, then master 0 wins first
        $display("[TB] scenario 5: reset while active");
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Let the monitor drain the queue within a bounded number of cycles
        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
